// File: rtl/dial_cmd_sequencer.sv
// dial_cmd_sequencer: parses an ASCII "L68\nR48\n" stream into
// direction/distance rotation commands for the dial core.
module dial_cmd_sequencer #(
  parameter int DIST_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_dir,
  output logic [DIST_W-1:0] cmd_dist,
  output logic [CNT_W-1:0]  cmd_count,
  output logic              done,
  output logic              err
);

  localparam int AW = DIST_W + 4;
  localparam logic [AW-1:0] MAX_DIST = AW'((1 << DIST_W) - 1);

  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  typedef enum logic [2:0] {
    IDLE, DIR, DIGITS, ISSUE, DONE, ERROR
  } state_t;

  state_t state, nxt;

  logic [DIST_W-1:0] acc, acc_nxt;
  logic              dir_r, dir_nxt;
  logic              last_pending, lp_nxt;

  logic          in_fire;
  logic          is_dir, is_ws, is_term, is_digit;
  logic [3:0]    dval;
  logic [AW-1:0] acc_mul;
  logic          ovf;

  assign in_fire  = in_valid & in_ready;
  assign is_dir   = (in_byte == CH_L) || (in_byte == CH_R);
  assign is_term  = (in_byte == CH_LF) || (in_byte == CH_CR);
  assign is_ws    = is_term || (in_byte == CH_SP);
  assign is_digit = (in_byte >= CH_0) && (in_byte <= CH_9);
  assign dval     = in_byte[3:0];
  assign acc_mul  = AW'(acc) * AW'(10) + AW'(dval);
  assign ovf      = acc_mul > MAX_DIST;

  always_comb begin
    nxt     = state;
    acc_nxt = acc;
    dir_nxt = dir_r;
    lp_nxt  = last_pending;
    unique case (state)
      IDLE: if (in_fire) begin
        if (is_dir) begin
          if (in_last) begin
            nxt = ERROR;
          end else begin
            nxt     = DIR;
            dir_nxt = (in_byte == CH_R);
            acc_nxt = '0;
          end
        end else if (is_ws) begin
          if (in_last) nxt = DONE;
        end else begin
          nxt = ERROR;
        end
      end
      DIR: if (in_fire) begin
        if (is_digit) begin
          acc_nxt = DIST_W'(dval);
          lp_nxt  = in_last;
          nxt     = in_last ? ISSUE : DIGITS;
        end else begin
          nxt = ERROR;
        end
      end
      DIGITS: if (in_fire) begin
        if (is_digit) begin
          if (ovf) begin
            nxt = ERROR;
          end else begin
            acc_nxt = acc_mul[DIST_W-1:0];
            lp_nxt  = in_last;
            nxt     = in_last ? ISSUE : DIGITS;
          end
        end else if (is_term) begin
          lp_nxt = in_last;
          nxt    = ISSUE;
        end else begin
          nxt = ERROR;
        end
      end
      ISSUE: if (cmd_ready) begin
        nxt = last_pending ? DONE : IDLE;
      end
      DONE:  nxt = DONE;
      ERROR: nxt = ERROR;
      default: nxt = ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      dir_r        <= 1'b0;
      last_pending <= 1'b0;
      in_ready     <= 1'b1;
      cmd_valid    <= 1'b0;
      cmd_dir      <= 1'b0;
      cmd_dist     <= '0;
      cmd_count    <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= nxt;
      acc          <= acc_nxt;
      dir_r        <= dir_nxt;
      last_pending <= lp_nxt;
      in_ready     <= (nxt == IDLE) || (nxt == DIR) || (nxt == DIGITS);
      cmd_valid    <= (nxt == ISSUE);
      done         <= (nxt == DONE);
      err          <= (nxt == ERROR);
      // command fields are captured once on ISSUE entry and held after
      if (nxt == ISSUE && state != ISSUE) begin
        cmd_dir  <= dir_nxt;
        cmd_dist <= acc_nxt;
      end
      if (state == ISSUE && cmd_ready) begin
        cmd_count <= cmd_count + 1'b1;
      end
    end
  end

endmodule
